// File: rtl/hdmi_timing_gen_pkg.sv
// Shared 640x480@60 raster constants and the per-axis phase type.
// Holds H/V porch/sync/visible counts, derived totals and phase_e.
package starsoc_params;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;

  localparam int unsigned H_TOTAL =
    H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL =
    V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam bit SYNC_ACTIVE_LOW = 1'b1;

  typedef enum logic [1:0] {
    ACT,
    FP,
    SY,
    BP
  } phase_e;

endpackage

// File: rtl/hdmi_timing_gen_axis_counter.sv
// One raster axis: 10-bit wrapping counter plus ACT/FP/SY/BP phase FSM.
// Ports: clk_i, rst_ni, adv_i in; count_o, phase_nxt_o, wrap_o, next_o out.
module timing_axis_counter
  import starsoc_params::*;
#(
  parameter int unsigned VIS   = 640,
  parameter int unsigned FRONT = 16,
  parameter int unsigned SYNC  = 96,
  parameter int unsigned BACK  = 48
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       adv_i,
  output logic [9:0] count_o,
  output phase_e     phase_nxt_o,
  output logic       wrap_o,
  output logic [9:0] next_o
);

  localparam logic [9:0] B_FP = 10'(VIS);
  localparam logic [9:0] B_SY = 10'(VIS + FRONT);
  localparam logic [9:0] B_BP = 10'(VIS + FRONT + SYNC);
  localparam logic [9:0] LAST =
    10'(VIS + FRONT + SYNC + BACK - 1);

  logic [9:0] count_q, count_d;
  phase_e     phase_q, phase_d;

  assign wrap_o = (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (adv_i) begin
      count_d = wrap_o ? '0 : count_q + 10'd1;
    end
  end

  // Phase changes only on the edge the count lands on a boundary.
  always_comb begin
    phase_d = phase_q;
    unique case (1'b1)
      (count_d == '0): phase_d = ACT;
      (count_d == B_FP): phase_d = FP;
      (count_d == B_SY): phase_d = SY;
      (count_d == B_BP): phase_d = BP;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= LAST;
      phase_q <= BP;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
    end
  end

  assign count_o     = count_q;
  assign phase_nxt_o = phase_d;
  assign next_o      = count_d;

endmodule

// File: rtl/hdmi_timing_gen.sv
// 640x480@60 raster timing generator: position, syncs, blank, markers.
// Ports: pixel_clk, reset_n, enable in; pixel_x/y, hsync, vsync, video_on,
// line_start, frame_start out; frame_count with HDMI_TIMING_FRAME_CNT_EN.
module hdmi_timing_gen #(
  parameter int unsigned H_VISIBLE = starsoc_params::H_VISIBLE,
  parameter int unsigned H_FRONT   = starsoc_params::H_FRONT,
  parameter int unsigned H_SYNC    = starsoc_params::H_SYNC,
  parameter int unsigned H_BACK    = starsoc_params::H_BACK,
  parameter int unsigned V_VISIBLE = starsoc_params::V_VISIBLE,
  parameter int unsigned V_FRONT   = starsoc_params::V_FRONT,
  parameter int unsigned V_SYNC    = starsoc_params::V_SYNC,
  parameter int unsigned V_BACK    = starsoc_params::V_BACK,
  parameter bit SYNC_ACTIVE_LOW    = starsoc_params::SYNC_ACTIVE_LOW
) (
  input  logic        pixel_clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        line_start,
  output logic        frame_start
`ifdef HDMI_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0] frame_count
`endif
);

  import starsoc_params::*;

  localparam logic SYNC_ON  = SYNC_ACTIVE_LOW ? 1'b0 : 1'b1;
  localparam logic SYNC_OFF = ~SYNC_ON;

  logic [9:0] h_nxt, v_nxt;
  logic       h_wrap, v_wrap;
  phase_e     h_ph, v_ph;

  timing_axis_counter #(
    .VIS(H_VISIBLE), .FRONT(H_FRONT),
    .SYNC(H_SYNC), .BACK(H_BACK)
  ) u_h (
    .clk_i(pixel_clk), .rst_ni(reset_n),
    .adv_i(enable),
    .count_o(pixel_x), .phase_nxt_o(h_ph),
    .wrap_o(h_wrap), .next_o(h_nxt)
  );

  timing_axis_counter #(
    .VIS(V_VISIBLE), .FRONT(V_FRONT),
    .SYNC(V_SYNC), .BACK(V_BACK)
  ) u_v (
    .clk_i(pixel_clk), .rst_ni(reset_n),
    .adv_i(enable & h_wrap),
    .count_o(pixel_y), .phase_nxt_o(v_ph),
    .wrap_o(v_wrap), .next_o(v_nxt)
  );

  logic hs_d, vs_d, vo_d, ls_d, fs_d;
  logic hs_q, vs_q, vo_q, ls_q, fs_q;

  // Strobes come from next-state values so they line up with the
  // counter registers; held next values keep levels stable.
  always_comb begin
    hs_d = (h_ph == SY) ? SYNC_ON : SYNC_OFF;
    vs_d = (v_ph == SY) ? SYNC_ON : SYNC_OFF;
    vo_d = (h_nxt < 10'(H_VISIBLE)) &&
           (v_nxt < 10'(V_VISIBLE));
    ls_d = enable & h_wrap;
    fs_d = enable & h_wrap & v_wrap;
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_q <= SYNC_OFF;
      vs_q <= SYNC_OFF;
      vo_q <= 1'b0;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      hs_q <= hs_d;
      vs_q <= vs_d;
      vo_q <= vo_d;
      ls_q <= ls_d;
      fs_q <= fs_d;
    end
  end

  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign video_on    = vo_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

`ifdef HDMI_TIMING_FRAME_CNT_EN
  logic [15:0] fcnt_q, fcnt_d;
  logic        seen_q, seen_d;

  // First frame after reset reads 0; later frames count up.
  always_comb begin
    fcnt_d = fcnt_q;
    seen_d = seen_q;
    if (fs_d) begin
      seen_d = 1'b1;
      if (seen_q) begin
        fcnt_d = fcnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      fcnt_q <= '0;
      seen_q <= 1'b0;
    end else begin
      fcnt_q <= fcnt_d;
      seen_q <= seen_d;
    end
  end

  assign frame_count = fcnt_q;
`endif

endmodule

// File: doc/hdmi_timing_gen.md
Name: hdmi_timing_gen

Overview:
- Raster timing generator for the 640x480@60 video path. Runs on the 25 MHz pixel clock.
- Produces the pixel position and the sync/blank strobes consumed by the downstream pixel-colour stage (video_gen), plus line and frame markers.
- Horizontal and vertical phase FSMs, all outputs registered and mutually aligned.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch in pixels
- H_SYNC, 96, horizontal sync width in pixels
- H_BACK, 48, horizontal back porch in pixels
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch in lines
- V_SYNC, 2, vertical sync width in lines
- V_BACK, 33, vertical back porch in lines
- SYNC_ACTIVE_LOW, 1, 1 = hsync/vsync asserted low

Ports:
- pixel_clk  in  1  pixel clock, 25 MHz
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  advance raster one pixel when high; hold all state when low
- pixel_x  out  10  current horizontal count, 0..H_TOTAL-1
- pixel_y  out  10  current vertical count, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, polarity per SYNC_ACTIVE_LOW
- vsync  out  1  vertical sync, polarity per SYNC_ACTIVE_LOW
- video_on  out  1  high when pixel_x < H_VISIBLE and pixel_y < V_VISIBLE
- line_start  out  1  one-cycle pulse when pixel_x becomes 0
- frame_start  out  1  one-cycle pulse when (pixel_x, pixel_y) becomes (0, 0)

Behaviour:
- Totals: H_TOTAL = sum of the H_* values (800); V_TOTAL = sum of the V_* values (525). Both are derived constants, 10-bit.
- Reset (asynchronous, reset_n low):
  - pixel_x = H_TOTAL-1 (799), pixel_y = V_TOTAL-1 (524).
  - video_on = 0, line_start = 0, frame_start = 0.
  - hsync and vsync inactive (1 when active-low).
  - The first enabled edge after release therefore presents (0,0) with frame_start = 1 and line_start = 1.
- Horizontal FSM states: H_ACT, H_FP, H_SY, H_BP. Transitions occur on the enabled edge where pixel_x enters the boundary value:
  - 0 enters H_ACT
  - H_VISIBLE enters H_FP
  - H_VISIBLE+H_FRONT enters H_SY
  - H_VISIBLE+H_FRONT+H_SYNC enters H_BP
  - H_TOTAL-1 wraps to 0, entering H_ACT
- Vertical FSM states: V_ACT, V_FP, V_SY, V_BP. Same structure, but advances only on the horizontal wrap edge. pixel_y wraps from V_TOTAL-1 to 0 on the horizontal wrap of the last line.
- Alignment:
  - hsync, vsync, video_on and the pulses are registered from next-state counter values.
  - In any cycle, every output describes the same (pixel_x, pixel_y). There is no skew between position and strobes.
- hsync asserted exactly for pixel_x in [656, 751]. vsync asserted exactly for pixel_y in [490, 491] over the whole line.
- enable low: counters, FSMs and the level outputs hold. line_start and frame_start are forced to 0 during a held cycle, so a pulse is never stretched.
- Reset mid-frame: immediate return to the reset state. No partial-line completion.
- Simultaneous horizontal and vertical wrap: pixel_x becomes 0 and pixel_y becomes 0 on the same edge; frame_start and line_start both pulse.
- Counter arithmetic is 10-bit unsigned. Comparisons use exact boundaries; no counter ever exceeds TOTAL-1.

Optional Feature:
- Macro: HDMI_TIMING_FRAME_CNT_EN.
- Defined: adds output port frame_count (16-bit).
  - Reset value 0.
  - Increments on every frame_start pulse except the first one after reset.
  - Wraps from 0xFFFF to 0.
- Undefined: port absent and no counter logic; all other behaviour identical.

Decomposition:
- starsoc_params package holds:
  - 640x480 timing constants (H_VISIBLE .. V_BACK) and the derived H_TOTAL/V_TOTAL
  - typedef enum for raster phase (ACT, FP, SY, BP), shared by both axes
- One sub-module: timing_axis_counter.
  - Parameterised visible/front/sync/back counts.
  - Inputs: advance strobe; outputs: count, phase, wrap flag, next-count.
  - Instantiated twice: horizontal, advanced by enable; vertical, advanced by enable AND horizontal wrap.

Test Plan:
- Release reset with enable = 1 -> first edge: pixel_x = 0, pixel_y = 0, frame_start = 1, line_start = 1, video_on = 1, hsync = 1, vsync = 1.
- Run one line -> video_on falls at pixel_x = 640; hsync low for pixel_x 656..751 (96 cycles); line_start pulses again 800 cycles after the previous one; pixel_y = 1.
- Run a full frame -> frame_start pulses every 420000 enabled cycles; vsync low for lines 490 and 491 (1600 cycles); video_on never high when pixel_y ≥ 480.
- Drop enable for 5 cycles at pixel_x = 799, pixel_y = 524 -> all outputs hold with no pulses. On re-enable: (0,0) appears with frame_start and line_start high for exactly 1 cycle.
- Assert reset_n low at pixel_x = 300, pixel_y = 200 -> outputs go to 799/524, video_on = 0, sync inactive, without waiting for a clock edge. Release -> restart at (0,0).
- With HDMI_TIMING_FRAME_CNT_EN defined, run 3 frames -> frame_count reads 0, 1, 2 at successive frame_start pulses. With the macro undefined, the bench compiles without the port.
